// File: rtl/coin_sched_pkg.sv
// coin_sched_pkg
// Shared types and width helpers for the coin pulse scheduler.
//   cs_state_t      : scheduler FSM states (idle, coin held low, spacing gap)
//   timer_width()   : bits needed to count down the longer of the pulse/gap
//   pending_width() : bits for the visible queued-coin count (0..max_pending)
//   sum_width()     : bits for pending + simultaneous edges, so the sum never wraps
//   inc_width()     : bits for the number of edges seen in one cycle
package coin_sched_pkg;

  typedef enum logic [1:0] {
    CS_IDLE,
    CS_PULSE,
    CS_GAP
  } cs_state_t;

  // A single-cycle pulse or gap still needs a one-bit timer.
  function automatic int timer_width(int pulse_cycles, int gap_cycles);
    int longest;
    longest = (pulse_cycles > gap_cycles) ? pulse_cycles : gap_cycles;
    return ($clog2(longest) < 1) ? 1 : $clog2(longest);
  endfunction

  function automatic int pending_width(int max_pending);
    return $clog2(max_pending + 1);
  endfunction

  function automatic int sum_width(int max_pending, int num_src);
    return $clog2(max_pending + num_src + 1);
  endfunction

  function automatic int inc_width(int num_src);
    return $clog2(num_src + 1);
  endfunction

  localparam int CS_DEF_NUM_SRC      = 3;
  localparam int CS_DEF_PULSE_CYCLES = 1200000;
  localparam int CS_DEF_GAP_CYCLES   = 1200000;
  localparam int CS_DEF_MAX_PENDING  = 7;

  localparam int CS_DEF_TIMER_W   = timer_width(CS_DEF_PULSE_CYCLES, CS_DEF_GAP_CYCLES);
  localparam int CS_DEF_PENDING_W = pending_width(CS_DEF_MAX_PENDING);

endpackage

// File: rtl/coin_edge_counter.sv
// coin_edge_counter
// Detects rising edges on every coin request source and reports how many
// new coins arrived this cycle.
//   clk_sys  in  : system clock, rising edge
//   reset_n  in  : synchronous active-low reset
//   req_in   in  : raw active-high button levels, NUM_SRC wide
//   enable   in  : 0 suppresses the count (edges are still tracked)
//   inc      out : number of coins to add this cycle
module coin_edge_counter #(
  parameter int NUM_SRC = 3,
  parameter int INC_W   = 2
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] req_in,
  input  logic               enable,
  output logic [INC_W-1:0]   inc
);

  logic [NUM_SRC-1:0] prev_req;
  logic [NUM_SRC-1:0] rise;
  logic [INC_W-1:0]   rise_count;

  // Previous levels reset to all-ones so a button held through reset looks
  // like it was already pressed and never produces a coin until re-pressed.
  // The history updates even while disabled so a level that rose during
  // disable cannot be counted later when enable returns.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      prev_req <= '1;
    end else begin
      prev_req <= req_in;
    end
  end

  // Each source contributes one coin per rising edge; simultaneous edges
  // add up rather than collapsing into one coin.
  always_comb begin
    rise       = req_in & ~prev_req;
    rise_count = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rise_count = rise_count + INC_W'(rise[i]);
    end
    inc = enable ? rise_count : '0;
  end

endmodule

// File: rtl/coin_pulse_scheduler.sv
// coin_pulse_scheduler
// Serialises coin requests from several sources into one active-low coin
// line: each press is queued and later played back as a fixed-width low
// pulse, with a fixed high gap between consecutive coins.
//   clk_sys     in  : system clock, rising edge
//   reset_n     in  : synchronous active-low reset
//   req_in      in  : raw active-high button levels, NUM_SRC wide
//   enable      in  : 0 ignores new presses; queued/in-flight coins continue
//   coin_out_n  out : registered active-low coin to the core
//   busy        out : 1 while a pulse or its trailing gap is running
//   pending     out : coins queued but not yet started
//   overflow    out : sticky, a press was dropped because the queue was full
module coin_pulse_scheduler
  import coin_sched_pkg::*;
#(
  parameter int  NUM_SRC      = CS_DEF_NUM_SRC,
  parameter int  PULSE_CYCLES = CS_DEF_PULSE_CYCLES,
  parameter int  GAP_CYCLES   = CS_DEF_GAP_CYCLES,
  parameter int  MAX_PENDING  = CS_DEF_MAX_PENDING,
  localparam int PENDING_W    = pending_width(MAX_PENDING)
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic [NUM_SRC-1:0]   req_in,
  input  logic                 enable,
  output logic                 coin_out_n,
  output logic                 busy,
  output logic [PENDING_W-1:0] pending,
  output logic                 overflow
);

  localparam int TIMER_W = timer_width(PULSE_CYCLES, GAP_CYCLES);
  localparam int SUM_W   = sum_width(MAX_PENDING, NUM_SRC);
  localparam int INC_W   = inc_width(NUM_SRC);

  localparam logic [TIMER_W-1:0]   PULSE_LOAD = TIMER_W'(PULSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0]   GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [TIMER_W-1:0]   TIMER_ONE  = TIMER_W'(1);
  localparam logic [SUM_W-1:0]     SUM_ONE    = SUM_W'(1);
  localparam logic [SUM_W-1:0]     SUM_MAX    = SUM_W'(MAX_PENDING);
  localparam logic [PENDING_W-1:0] PEND_MAX   = PENDING_W'(MAX_PENDING);

  cs_state_t            state;
  cs_state_t            state_next;
  logic [TIMER_W-1:0]   timer;
  logic [TIMER_W-1:0]   timer_next;
  logic                 dec;
  logic [INC_W-1:0]     inc;
  logic [SUM_W-1:0]     pending_sum;
  logic [PENDING_W-1:0] pending_next;
  logic                 saturate;

  coin_edge_counter #(
    .NUM_SRC (NUM_SRC),
    .INC_W   (INC_W)
  ) u_edge_counter (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .req_in  (req_in),
    .enable  (enable),
    .inc     (inc)
  );

  // Next-state logic. The timer counts down to zero and the state changes on
  // the cycle it reads zero, so loading N-1 yields exactly N cycles in a
  // state. A coin is taken off the queue only when a new pulse starts.
  always_comb begin
    state_next = state;
    timer_next = timer;
    dec        = 1'b0;
    case (state)
      CS_IDLE: begin
        if (pending != '0) begin
          state_next = CS_PULSE;
          timer_next = PULSE_LOAD;
          dec        = 1'b1;
        end
      end
      CS_PULSE: begin
        if (timer == '0) begin
          state_next = CS_GAP;
          timer_next = GAP_LOAD;
        end else begin
          timer_next = timer - TIMER_ONE;
        end
      end
      CS_GAP: begin
        if (timer == '0) begin
          if (pending != '0) begin
            state_next = CS_PULSE;
            timer_next = PULSE_LOAD;
            dec        = 1'b1;
          end else begin
            state_next = CS_IDLE;
          end
        end else begin
          timer_next = timer - TIMER_ONE;
        end
      end
      default: begin
        state_next = CS_IDLE;
        timer_next = '0;
      end
    endcase
  end

  // Queue arithmetic is done wide enough for pending plus every source
  // firing at once, so a burst can never wrap; the result is then clamped.
  // Saturation is judged on the net value after a same-cycle decrement.
  always_comb begin
    pending_sum = SUM_W'(pending) + SUM_W'(inc);
    if (dec && (pending != '0)) begin
      pending_sum = pending_sum - SUM_ONE;
    end
    saturate     = (pending_sum > SUM_MAX);
    pending_next = saturate ? PEND_MAX : pending_sum[PENDING_W-1:0];
  end

  // Registered outputs are derived from the next state so the coin line
  // comes straight out of a flop and cannot glitch on state decoding.
  // Reset drops any pulse in progress on the very first reset edge.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state      <= CS_IDLE;
      timer      <= '0;
      pending    <= '0;
      overflow   <= 1'b0;
      coin_out_n <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      pending    <= pending_next;
      coin_out_n <= (state_next != CS_PULSE);
      busy       <= (state_next != CS_IDLE);
      if (saturate) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_coin_pulse_scheduler.sv
// tb_coin_pulse_scheduler
// Directed bench for coin_pulse_scheduler with short pulse/gap lengths.
// A vector table covers exact cycle-by-cycle timing of single coins and a
// same-cycle enqueue/dequeue; hand sequences cover bursts, saturation,
// held buttons, reset mid-pulse and enable gating.
module tb_coin_pulse_scheduler;

  localparam int NUM_SRC      = 3;
  localparam int PULSE_CYCLES = 4;
  localparam int GAP_CYCLES   = 3;
  localparam int MAX_PENDING  = 3;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] req_in  = 3'b000;
  logic       enable  = 1'b1;
  logic       coin_out_n;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int error_count = 0;
  int check_count = 0;
  int pulse_count;
  int low_cycles;
  int busy_cycles;
  logic prev_coin;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [2:0] req;
    logic       exp_coin_n;
    logic       exp_busy;
    logic [1:0] exp_pending;
    logic       exp_overflow;
  } vec_t;

  vec_t vectors[$];

  coin_pulse_scheduler #(
    .NUM_SRC      (NUM_SRC),
    .PULSE_CYCLES (PULSE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES),
    .MAX_PENDING  (MAX_PENDING)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .req_in     (req_in),
    .enable     (enable),
    .coin_out_n (coin_out_n),
    .busy       (busy),
    .pending    (pending),
    .overflow   (overflow)
  );

  // Free-running 10-unit clock.
  always #5 clk_sys = ~clk_sys;

  // Drive one cycle of inputs, clock once, and settle just past the edge.
  task automatic applyStimulus(input logic rst_n, input logic en, input logic [2:0] req);
    reset_n = rst_n;
    enable  = en;
    req_in  = req;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual != expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic addVector(input logic rst_n, input logic en, input logic [2:0] req,
                           input logic c, input logic b, input logic [1:0] p, input logic o);
    vec_t v;
    v.rst_n        = rst_n;
    v.en           = en;
    v.req          = req;
    v.exp_coin_n   = c;
    v.exp_busy     = b;
    v.exp_pending  = p;
    v.exp_overflow = o;
    vectors.push_back(v);
  endtask

  task automatic resetCounters();
    pulse_count = 0;
    low_cycles  = 0;
    busy_cycles = 0;
    prev_coin   = coin_out_n;
  endtask

  // Clock n cycles with fixed inputs, counting falling coin edges, low
  // cycles and busy cycles as seen just after each edge.
  task automatic runSteps(input logic rst_n, input logic en, input logic [2:0] req, input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(rst_n, en, req);
      if (prev_coin && !coin_out_n) pulse_count++;
      if (!coin_out_n) low_cycles++;
      if (busy) busy_cycles++;
      prev_coin = coin_out_n;
    end
  endtask

  initial begin
    // Single press: one coin, low 4 cycles from the 2nd edge, 3 gap cycles.
    addVector(1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 2'd0, 1'b0);
    addVector(1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 2'd0, 1'b0);
    addVector(1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 2'd1, 1'b0);
    for (int i = 0; i < 4; i++) addVector(1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) addVector(1'b1, 1'b1, 3'b000, 1'b1, 1'b1, 2'd0, 1'b0);
    addVector(1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 2'd0, 1'b0);
    // New edge in the same cycle a coin is dequeued: net pending stays 1.
    addVector(1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 2'd1, 1'b0);
    addVector(1'b1, 1'b1, 3'b011, 1'b0, 1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) addVector(1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) addVector(1'b1, 1'b1, 3'b000, 1'b1, 1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 4; i++) addVector(1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) addVector(1'b1, 1'b1, 3'b000, 1'b1, 1'b1, 2'd0, 1'b0);
    addVector(1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 2'd0, 1'b0);

    for (int i = 0; i < vectors.size(); i++) begin
      applyStimulus(vectors[i].rst_n, vectors[i].en, vectors[i].req);
      checkOutput($sformatf("vec%0d coin_out_n", i), int'(coin_out_n), int'(vectors[i].exp_coin_n));
      checkOutput($sformatf("vec%0d busy", i), int'(busy), int'(vectors[i].exp_busy));
      checkOutput($sformatf("vec%0d pending", i), int'(pending), int'(vectors[i].exp_pending));
      checkOutput($sformatf("vec%0d overflow", i), int'(overflow), int'(vectors[i].exp_overflow));
    end

    // Simultaneous edges on all sources: three coins, 21 busy cycles.
    $display("[TB] simultaneous press");
    applyStimulus(1'b1, 1'b1, 3'b111);
    checkOutput("sim pending", int'(pending), 3);
    resetCounters();
    runSteps(1'b1, 1'b1, 3'b000, 40);
    checkOutput("sim pulses", pulse_count, 3);
    checkOutput("sim low cycles", low_cycles, 12);
    checkOutput("sim busy cycles", busy_cycles, 21);
    checkOutput("sim end pending", int'(pending), 0);

    // Saturation: queue clamps at 3, overflow sticks, 4 coins in total.
    $display("[TB] saturation");
    applyStimulus(1'b1, 1'b1, 3'b111);
    checkOutput("sat pending", int'(pending), 3);
    checkOutput("sat overflow before", int'(overflow), 0);
    resetCounters();
    runSteps(1'b1, 1'b1, 3'b000, 1);
    runSteps(1'b1, 1'b1, 3'b011, 1);
    checkOutput("sat clamp pending", int'(pending), 3);
    checkOutput("sat overflow", int'(overflow), 1);
    runSteps(1'b1, 1'b1, 3'b000, 60);
    checkOutput("sat pulses", pulse_count, 4);
    checkOutput("sat overflow sticky", int'(overflow), 1);
    checkOutput("sat end busy", int'(busy), 0);

    // Held button: a level held for 50 cycles yields exactly one coin.
    $display("[TB] held button");
    resetCounters();
    runSteps(1'b1, 1'b1, 3'b001, 50);
    runSteps(1'b1, 1'b1, 3'b000, 10);
    checkOutput("held pulses", pulse_count, 1);
    checkOutput("held low cycles", low_cycles, 4);

    // Reset in the second pulse cycle with a button held through it.
    $display("[TB] reset mid-pulse");
    applyStimulus(1'b1, 1'b1, 3'b011);
    checkOutput("rst queued", int'(pending), 2);
    applyStimulus(1'b1, 1'b1, 3'b011);
    checkOutput("rst pulse started", int'(coin_out_n), 0);
    applyStimulus(1'b0, 1'b1, 3'b011);
    checkOutput("rst coin_out_n", int'(coin_out_n), 1);
    checkOutput("rst pending", int'(pending), 0);
    checkOutput("rst busy", int'(busy), 0);
    checkOutput("rst overflow", int'(overflow), 0);
    resetCounters();
    runSteps(1'b1, 1'b1, 3'b011, 10);
    checkOutput("rst held no pulse", pulse_count, 0);
    checkOutput("rst held pending", int'(pending), 0);
    applyStimulus(1'b1, 1'b1, 3'b000);
    applyStimulus(1'b1, 1'b1, 3'b001);
    checkOutput("rst repress pending", int'(pending), 1);
    resetCounters();
    runSteps(1'b1, 1'b1, 3'b000, 12);
    checkOutput("rst repress pulses", pulse_count, 1);

    // Enable gating: presses ignored while disabled, queued coin completes.
    $display("[TB] enable gating");
    applyStimulus(1'b1, 1'b0, 3'b010);
    checkOutput("en0 pending", int'(pending), 0);
    applyStimulus(1'b1, 1'b1, 3'b010);
    checkOutput("en1 held level pending", int'(pending), 0);
    applyStimulus(1'b1, 1'b1, 3'b000);
    applyStimulus(1'b1, 1'b1, 3'b100);
    checkOutput("en queued pending", int'(pending), 1);
    resetCounters();
    runSteps(1'b1, 1'b0, 3'b001, 15);
    checkOutput("en queued pulses", pulse_count, 1);
    checkOutput("en queued low cycles", low_cycles, 4);
    checkOutput("en end pending", int'(pending), 0);
    checkOutput("en end busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
